// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
//   Shares the register file's single write port among NREQ writeback
//   sources. Round-robin arbitration with a valid/ready handshake per
//   requester and one registered output stage driving rf_we/rf_waddr/rf_wdata.
//   Writes to r0 are accepted (ready, pointer advance) but never issued.
//
// Configuration macro: RF_WB_BYPASS_EN
//   defined   : byp_hitN/byp_dataN expose the pending output-stage write.
//   undefined : bypass outputs tied to 0, byp_raddrN ignored.
//   The port list is identical in both builds.
//
// Ports
//   clk, reset            clock; synchronous active-high reset
//   req_valid[NREQ]       requester i holds a valid write
//   req_waddr[NREQ*AW]    requester i address at [i*AW +: AW]
//   req_wdata[NREQ*DW]    requester i data at [i*DW +: DW]
//   req_ready[NREQ]       one-hot (or zero) accept strobe
//   rf_stall              blocks all new grants this cycle
//   rf_we/rf_waddr/rf_wdata  register file write port (registered)
//   grant_id[3]           requester that produced the current rf_* entry
//   byp_raddr1/2          bypass lookup addresses
//   byp_hit1/2, byp_data1/2  bypass match flags and data
module rf_wb_arbiter #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned AW   = 5,
  parameter int unsigned DW   = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_waddr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    req_ready,
  input  logic               rf_stall,
  output logic               rf_we,
  output logic [AW-1:0]      rf_waddr,
  output logic [DW-1:0]      rf_wdata,
  output logic [2:0]         grant_id,
  input  logic [AW-1:0]      byp_raddr1,
  input  logic [AW-1:0]      byp_raddr2,
  output logic               byp_hit1,
  output logic               byp_hit2,
  output logic [DW-1:0]      byp_data1,
  output logic [DW-1:0]      byp_data2
);

  localparam logic [2:0] LAST_RST = 3'(NREQ - 1);

  logic [2:0]    last_q, last_d;
  logic          rf_we_q, rf_we_d;
  logic [AW-1:0] rf_waddr_q, rf_waddr_d;
  logic [DW-1:0] rf_wdata_q, rf_wdata_d;
  logic [2:0]    grant_id_q, grant_id_d;

  logic          hit_hi, hit_lo;
  logic [2:0]    idx_hi, idx_lo, win_idx;
  logic          grant;
  logic [AW-1:0] sel_waddr;
  logic [DW-1:0] sel_wdata;

  // Rotating priority split into two linear scans: the lowest valid index
  // above the pointer wins; failing that, the lowest valid index at or below
  // it. This equals scanning last+1, last+2, ... modulo NREQ.
  always_comb begin
    hit_hi = 1'b0;
    hit_lo = 1'b0;
    idx_hi = '0;
    idx_lo = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (req_valid[i]) begin
        if (i > 32'(last_q)) begin
          if (!hit_hi) begin
            hit_hi = 1'b1;
            idx_hi = 3'(i);
          end
        end else if (!hit_lo) begin
          hit_lo = 1'b1;
          idx_lo = 3'(i);
        end
      end
    end
  end

  always_comb begin
    win_idx   = hit_hi ? idx_hi : idx_lo;
    grant     = !reset && !rf_stall && (hit_hi || hit_lo);
    req_ready = '0;
    sel_waddr = '0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (32'(win_idx) == i) begin
        req_ready[i] = grant;
        sel_waddr    = req_waddr[i*AW +: AW];
        sel_wdata    = req_wdata[i*DW +: DW];
      end
    end
  end

  always_comb begin
    rf_we_d    = grant && (sel_waddr != '0);
    rf_waddr_d = grant ? sel_waddr : rf_waddr_q;
    rf_wdata_d = grant ? sel_wdata : rf_wdata_q;
    grant_id_d = grant ? win_idx   : grant_id_q;
    last_d     = grant ? win_idx   : last_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      grant_id_q <= '0;
      last_q     <= LAST_RST;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      grant_id_q <= grant_id_d;
      last_q     <= last_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign grant_id = grant_id_q;

`ifdef RF_WB_BYPASS_EN
  // Exposes the write the register file commits on the next edge.
  assign byp_hit1  = rf_we_q && (rf_waddr_q == byp_raddr1) && (byp_raddr1 != '0);
  assign byp_hit2  = rf_we_q && (rf_waddr_q == byp_raddr2) && (byp_raddr2 != '0);
  assign byp_data1 = byp_hit1 ? rf_wdata_q : '0;
  assign byp_data2 = byp_hit2 ? rf_wdata_q : '0;
`else
  logic unused_byp;
  assign unused_byp = ^{byp_raddr1, byp_raddr2};
  assign byp_hit1   = 1'b0;
  assign byp_hit2   = 1'b0;
  assign byp_data1  = '0;
  assign byp_data2  = '0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;

  localparam int unsigned NREQ = 3;
  localparam int unsigned AW   = 5;
  localparam int unsigned DW   = 32;

`ifdef RF_WB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               reset;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_waddr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    req_ready;
  logic               rf_stall;
  logic               rf_we;
  logic [AW-1:0]      rf_waddr;
  logic [DW-1:0]      rf_wdata;
  logic [2:0]         grant_id;
  logic [AW-1:0]      byp_raddr1, byp_raddr2;
  logic               byp_hit1, byp_hit2;
  logic [DW-1:0]      byp_data1, byp_data2;

  rf_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_waddr(req_waddr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rf_stall(rf_stall),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .grant_id(grant_id),
    .byp_raddr1(byp_raddr1), .byp_raddr2(byp_raddr2),
    .byp_hit1(byp_hit1), .byp_hit2(byp_hit2),
    .byp_data1(byp_data1), .byp_data2(byp_data2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          stall;
    logic [2:0]    valid;
    logic [AW-1:0] a0, a1, a2;
    logic [DW-1:0] d0, d1, d2;
    logic [AW-1:0] br1, br2;
    logic [2:0]    e_ready;
    logic          e_we;
    logic [AW-1:0] e_waddr;
    logic [DW-1:0] e_wdata;
    logic [2:0]    e_gid;
    logic          e_h1;
    logic [DW-1:0] e_d1;
    logic          e_h2;
    logic [DW-1:0] e_d2;
  } vec_t;

  vec_t vq[$];
  int n_cmp = 0;
  int n_err = 0;

  function automatic vec_t mk(
    logic rst, logic stall, logic [2:0] valid,
    logic [AW-1:0] a0, logic [AW-1:0] a1, logic [AW-1:0] a2,
    logic [DW-1:0] d0, logic [DW-1:0] d1, logic [DW-1:0] d2,
    logic [AW-1:0] br1, logic [AW-1:0] br2,
    logic [2:0] e_ready, logic e_we, logic [AW-1:0] e_waddr,
    logic [DW-1:0] e_wdata, logic [2:0] e_gid,
    logic e_h1, logic [DW-1:0] e_d1, logic e_h2, logic [DW-1:0] e_d2);
    vec_t v;
    v.rst = rst; v.stall = stall; v.valid = valid;
    v.a0 = a0; v.a1 = a1; v.a2 = a2;
    v.d0 = d0; v.d1 = d1; v.d2 = d2;
    v.br1 = br1; v.br2 = br2;
    v.e_ready = e_ready; v.e_we = e_we; v.e_waddr = e_waddr;
    v.e_wdata = e_wdata; v.e_gid = e_gid;
    v.e_h1 = e_h1; v.e_d1 = e_d1; v.e_h2 = e_h2; v.e_d2 = e_d2;
    return v;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    reset      = v.rst;
    rf_stall   = v.stall;
    req_valid  = v.valid;
    req_waddr  = {v.a2, v.a1, v.a0};
    req_wdata  = {v.d2, v.d1, v.d0};
    byp_raddr1 = v.br1;
    byp_raddr2 = v.br2;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned waited;
    logic [2:0] exp_gid_a [4];
    logic [2:0] exp_rdy_a [4];

    reset = 1'b1; rf_stall = 1'b0; req_valid = '0; req_waddr = '0;
    req_wdata = '0; byp_raddr1 = '0; byp_raddr2 = '0;

    // reset 3 cycles with all valid
    for (int unsigned k = 0; k < 3; k++)
      vq.push_back(mk(1,0,3'b111, 1,2,3, 'h100,'h200,'h300, 7,0,
                      3'b000, 0, 0, 'h0, 0, 0,'h0, 0,'h0));
    // all valid: rotation 0,1,2,0,1,2
    vq.push_back(mk(0,0,3'b111, 1,2,3, 'h100,'h200,'h300, 7,0, 3'b001, 1, 1,'h100, 0, 0,'h0, 0,'h0));
    vq.push_back(mk(0,0,3'b111, 1,2,3, 'h100,'h200,'h300, 7,0, 3'b010, 1, 2,'h200, 1, 0,'h0, 0,'h0));
    vq.push_back(mk(0,0,3'b111, 1,2,3, 'h100,'h200,'h300, 7,0, 3'b100, 1, 3,'h300, 2, 0,'h0, 0,'h0));
    vq.push_back(mk(0,0,3'b111, 1,2,3, 'h100,'h200,'h300, 7,0, 3'b001, 1, 1,'h100, 0, 0,'h0, 0,'h0));
    vq.push_back(mk(0,0,3'b111, 1,2,3, 'h100,'h200,'h300, 7,0, 3'b010, 1, 2,'h200, 1, 0,'h0, 0,'h0));
    vq.push_back(mk(0,0,3'b111, 1,2,3, 'h100,'h200,'h300, 7,0, 3'b100, 1, 3,'h300, 2, 0,'h0, 0,'h0));
    // r0 write from req1: consumed, not issued, pointer -> 1
    vq.push_back(mk(0,0,3'b010, 1,0,3, 'h100,'hDEADBEEF,'h300, 7,0, 3'b010, 0, 0,'hDEADBEEF, 1, 0,'h0, 0,'h0));
    vq.push_back(mk(0,0,3'b111, 1,2,3, 'h100,'h200,'h300, 7,0, 3'b100, 1, 3,'h300, 2, 0,'h0, 0,'h0));
    // stall two cycles, outputs hold, then r5=0x11 issues
    vq.push_back(mk(0,1,3'b001, 5,2,3, 'h11,'h200,'h300, 7,0, 3'b000, 0, 3,'h300, 2, 0,'h0, 0,'h0));
    vq.push_back(mk(0,1,3'b001, 5,2,3, 'h11,'h200,'h300, 7,0, 3'b000, 0, 3,'h300, 2, 0,'h0, 0,'h0));
    vq.push_back(mk(0,0,3'b001, 5,2,3, 'h11,'h200,'h300, 7,5, 3'b001, 1, 5,'h11, 0,
                    0,'h0, BYP, BYP ? 32'h11 : 32'h0));
    // accept r7=0xA5, bypass lookup on r7 / r0
    vq.push_back(mk(0,0,3'b001, 7,2,3, 'hA5,'h200,'h300, 7,0, 3'b001, 1, 7,'hA5, 0,
                    BYP, BYP ? 32'hA5 : 32'h0, 0,'h0));
    // reset discards in-flight r7
    vq.push_back(mk(1,0,3'b000, 7,2,3, 'hA5,'h200,'h300, 7,0, 3'b000, 0, 0,'h0, 0, 0,'h0, 0,'h0));
    vq.push_back(mk(0,0,3'b000, 7,2,3, 'hA5,'h200,'h300, 7,0, 3'b000, 0, 0,'h0, 0, 0,'h0, 0,'h0));

    foreach (vq[i]) begin
      @(negedge clk);
      drive(vq[i]);
      #1;
      chk($sformatf("v%0d_ready", i), DW'(req_ready), DW'(vq[i].e_ready));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_we", i),    DW'(rf_we),     DW'(vq[i].e_we));
      chk($sformatf("v%0d_waddr", i), DW'(rf_waddr),  DW'(vq[i].e_waddr));
      chk($sformatf("v%0d_wdata", i), rf_wdata,       vq[i].e_wdata);
      chk($sformatf("v%0d_gid", i),   DW'(grant_id),  DW'(vq[i].e_gid));
      chk($sformatf("v%0d_hit1", i),  DW'(byp_hit1),  DW'(vq[i].e_h1));
      chk($sformatf("v%0d_data1", i), byp_data1,      vq[i].e_d1);
      chk($sformatf("v%0d_hit2", i),  DW'(byp_hit2),  DW'(vq[i].e_h2));
      chk($sformatf("v%0d_data2", i), byp_data2,      vq[i].e_d2);
    end

    // Sequence A: pointer at 2, req0 and req2 continuously valid -> 0,2,0,2
    exp_gid_a = '{3'd0, 3'd2, 3'd0, 3'd2};
    exp_rdy_a = '{3'b001, 3'b100, 3'b001, 3'b100};
    for (int unsigned k = 0; k < 4; k++) begin
      @(negedge clk);
      reset = 1'b0; rf_stall = 1'b0; req_valid = 3'b101;
      req_waddr = {5'd3, 5'd2, 5'd1};
      req_wdata = {32'h300, 32'h200, 32'h100};
      #1;
      chk($sformatf("seqA%0d_ready", k), DW'(req_ready), DW'(exp_rdy_a[k]));
      @(posedge clk);
      #1;
      chk($sformatf("seqA%0d_gid", k), DW'(grant_id), DW'(exp_gid_a[k]));
      chk($sformatf("seqA%0d_we", k),  DW'(rf_we),    32'd1);
    end

    // Sequence B: lone req1 (pointer at 2) is served at once; entry issues
    // one cycle later, then outputs hold with rf_we low once valid drops.
    @(negedge clk);
    req_valid = 3'b010;
    req_waddr = {5'd3, 5'd9, 5'd1};
    req_wdata = {32'h300, 32'h99, 32'h100};
    waited = 0;
    #1;
    while (!req_ready[1] && waited < 8) begin
      @(negedge clk);
      #1;
      waited++;
    end
    chk("seqB_wait", DW'(waited), 32'd0);
    @(posedge clk);
    #1;
    chk("seqB_we",    DW'(rf_we),    32'd1);
    chk("seqB_waddr", DW'(rf_waddr), 32'd9);
    chk("seqB_wdata", rf_wdata,      32'h99);
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("seqB_idle_ready", DW'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("seqB_idle_we",    DW'(rf_we),    32'd0);
    chk("seqB_idle_waddr", DW'(rf_waddr), 32'd9);
    chk("seqB_idle_gid",   DW'(grant_id), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
